// File: rtl/cv32e40x_xif_outstanding_tracker_pkg.sv
// Shared types for the XIF outstanding-instruction tracker.
package cv32e40x_xif_outstanding_tracker_pkg;

  typedef enum logic [1:0] {
    XIF_POP_NONE   = 2'd0,
    XIF_POP_KILL   = 2'd1,
    XIF_POP_RESULT = 2'd2
  } xif_trk_pop_e;

  typedef struct packed {
    logic writeback;
    logic committed;
    logic killed;
  } xif_trk_status_t;

  // A committed-and-killed entry leaves without waiting for a result.
  function automatic logic xif_trk_kill_retire(input xif_trk_status_t st);
    return st.committed & st.killed;
  endfunction

endpackage

// File: rtl/cv32e40x_xif_outstanding_tracker.sv
// Tracks offloaded XIF instructions from accept through commit/kill to result,
// in issue order, with full stall and a sticky protocol error flag.
module cv32e40x_xif_outstanding_tracker
  import cv32e40x_xif_outstanding_tracker_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic                    issue_ready,
  input  logic [X_ID_WIDTH-1:0]   issue_id,
  input  logic                    issue_accept,
  input  logic                    issue_writeback,
  input  logic                    commit_valid,
  input  logic [X_ID_WIDTH-1:0]   commit_id,
  input  logic                    commit_kill,
  input  logic                    result_valid,
  input  logic                    result_ready,
  input  logic [X_ID_WIDTH-1:0]   result_id,
  output logic                    issue_stall_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [X_ID_WIDTH-1:0]   head_id_o,
  output logic                    head_wb_o,
  output logic                    protocol_err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    xif_trk_status_t       st;
  } xif_trk_entry_t;

  xif_trk_entry_t            entries_q [DEPTH];
  xif_trk_entry_t            entries_d [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          cmt_ptr_q, cmt_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      protocol_err_q, protocol_err_d;
  logic                      issue_stall_q, issue_stall_d;
  logic                      empty_q, empty_d;
  logic [X_ID_WIDTH-1:0]     head_id_q, head_id_d;
  logic                      head_wb_q, head_wb_d;

  xif_trk_entry_t            head;
  xif_trk_entry_t            cmt_entry;
  xif_trk_entry_t            head_nxt;
  xif_trk_pop_e              pop_kind;
  logic                      full;
  logic                      is_empty;
  logic                      cmt_avail;
  logic                      do_push;
  logic                      do_pop;
  logic                      err;

  // Next-state: push, in-order commit, single pop, error detection, output precompute.
  always_comb begin
    entries_d      = entries_q;
    wr_ptr_d       = wr_ptr_q;
    cmt_ptr_d      = cmt_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    pop_kind       = XIF_POP_NONE;
    do_push        = 1'b0;
    err            = 1'b0;
    full           = (count_q == CNT_W'(DEPTH));
    is_empty       = (count_q == '0);
    head           = entries_q[rd_ptr_q];
    cmt_entry      = entries_q[cmt_ptr_q];
    // When full with cmt_ptr==wr_ptr, the slot's commit flag tells all-committed from none.
    cmt_avail      = (cmt_ptr_q != wr_ptr_q) || (full && !cmt_entry.st.committed);

    if (issue_valid && issue_ready && issue_accept) begin
      if (full) begin
        err = 1'b1;
      end else begin
        do_push             = 1'b1;
        entries_d[wr_ptr_q] = '{id: issue_id,
                                st: '{writeback: issue_writeback, committed: 1'b0, killed: 1'b0}};
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
    end

    if (commit_valid) begin
      if (!cmt_avail || (commit_id != cmt_entry.id)) begin
        err = 1'b1;
      end else begin
        entries_d[cmt_ptr_q].st.committed = 1'b1;
        entries_d[cmt_ptr_q].st.killed    = commit_kill;
        cmt_ptr_d                         = cmt_ptr_q + PTR_W'(1);
      end
    end

    if (!is_empty && xif_trk_kill_retire(head.st)) begin
      pop_kind = XIF_POP_KILL;
    end

    if (result_valid && result_ready) begin
      if (is_empty || (result_id != head.id) || !head.st.committed || head.st.killed) begin
        err = 1'b1;
      end else begin
        pop_kind = XIF_POP_RESULT;
      end
    end

    do_pop = (pop_kind != XIF_POP_NONE);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    protocol_err_d = protocol_err_q | err;
    head_nxt       = entries_d[rd_ptr_d];
    empty_d        = (count_d == '0);
    issue_stall_d  = (count_d == CNT_W'(DEPTH));
    head_id_d      = empty_d ? '0 : head_nxt.id;
    head_wb_d      = empty_d ? 1'b0 : head_nxt.st.writeback;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      cmt_ptr_q      <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      protocol_err_q <= 1'b0;
      issue_stall_q  <= 1'b0;
      empty_q        <= 1'b1;
      head_id_q      <= '0;
      head_wb_q      <= 1'b0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= entries_d[i];
      end
      wr_ptr_q       <= wr_ptr_d;
      cmt_ptr_q      <= cmt_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      protocol_err_q <= protocol_err_d;
      issue_stall_q  <= issue_stall_d;
      empty_q        <= empty_d;
      head_id_q      <= head_id_d;
      head_wb_q      <= head_wb_d;
    end
  end

  assign issue_stall_o  = issue_stall_q;
  assign empty_o        = empty_q;
  assign count_o        = count_q;
  assign head_id_o      = head_id_q;
  assign head_wb_o      = head_wb_q;
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_cv32e40x_xif_outstanding_tracker.sv
// Directed and randomized checks of the XIF outstanding tracker against a queue model.
module tb_cv32e40x_xif_outstanding_tracker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW   = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           issue_valid, issue_ready, issue_accept, issue_writeback;
  logic [IDW-1:0] issue_id;
  logic           commit_valid, commit_kill;
  logic [IDW-1:0] commit_id;
  logic           result_valid, result_ready;
  logic [IDW-1:0] result_id;
  logic           issue_stall_o, empty_o, head_wb_o, protocol_err_o;
  logic [2:0]     count_o;
  logic [IDW-1:0] head_id_o;

  cv32e40x_xif_outstanding_tracker #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .issue_stall_o(issue_stall_o), .empty_o(empty_o), .count_o(count_o),
    .head_id_o(head_id_o), .head_wb_o(head_wb_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic           wb;
    logic           cmt;
    logic           kil;
  } ent_t;

  ent_t mq[$];
  logic m_err;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int first_uncommitted();
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].cmt) return i;
    end
    return -1;
  endfunction

  // Apply one cycle of the tracker rules to the queue, using the pre-cycle queue.
  task automatic model_step();
    bit   err = 1'b0, push = 1'b0, pop = 1'b0;
    int   ci = -1;
    ent_t e;
    if (issue_valid && issue_ready && issue_accept) begin
      if (mq.size() == DEPTH) err = 1'b1;
      else push = 1'b1;
    end
    if (commit_valid) begin
      ci = first_uncommitted();
      if (ci < 0) err = 1'b1;
      else if (mq[ci].id != commit_id) begin
        err = 1'b1;
        ci  = -1;
      end
    end
    if (mq.size() > 0 && mq[0].cmt && mq[0].kil) pop = 1'b1;
    if (result_valid && result_ready) begin
      if (mq.size() == 0) err = 1'b1;
      else if (mq[0].id != result_id || !mq[0].cmt || mq[0].kil) err = 1'b1;
      else pop = 1'b1;
    end
    if (ci >= 0) begin
      e     = mq[ci];
      e.cmt = 1'b1;
      e.kil = commit_kill;
      mq[ci] = e;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.id = issue_id; e.wb = issue_writeback; e.cmt = 1'b0; e.kil = 1'b0;
      mq.push_back(e);
    end
    if (err) m_err = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    int n = mq.size();
    check({tag, "_count"}, 32'(count_o), 32'(n));
    check({tag, "_empty"}, 32'(empty_o), 32'(n == 0));
    check({tag, "_stall"}, 32'(issue_stall_o), 32'(n == DEPTH));
    check({tag, "_head_id"}, 32'(head_id_o), (n > 0) ? 32'(mq[0].id) : 32'd0);
    check({tag, "_head_wb"}, 32'(head_wb_o), (n > 0) ? 32'(mq[0].wb) : 32'd0);
    check({tag, "_err"}, 32'(protocol_err_o), 32'(m_err));
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_ready = 0; issue_accept = 0; issue_writeback = 0; issue_id = '0;
    commit_valid = 0; commit_kill = 0; commit_id = '0;
    result_valid = 0; result_ready = 0; result_id = '0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  // One handshake cycle; inputs return to idle afterwards.
  task automatic cyc(input bit iv, input bit ia, input logic [IDW-1:0] iid, input bit iwb,
                     input bit cv, input logic [IDW-1:0] cid, input bit ck,
                     input bit rv, input logic [IDW-1:0] rid, input string tag);
    issue_valid = iv; issue_ready = iv; issue_accept = ia; issue_id = iid; issue_writeback = iwb;
    commit_valid = cv; commit_id = cid; commit_kill = ck;
    result_valid = rv; result_ready = rv; result_id = rid;
    step(tag);
    idle_inputs();
  endtask

  task automatic iss(input logic [IDW-1:0] id, input bit wb);
    cyc(1, 1, id, wb, 0, '0, 0, 0, '0, "iss");
  endtask

  task automatic cmt(input logic [IDW-1:0] id, input bit k);
    cyc(0, 0, '0, 0, 1, id, k, 0, '0, "cmt");
  endtask

  task automatic res(input logic [IDW-1:0] id);
    cyc(0, 0, '0, 0, 0, '0, 0, 1, id, "res");
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_err = 1'b0;
    check_outputs("rst");
  endtask

  initial begin
    bit errmode;
    int ci;
    idle_inputs();
    m_err = 1'b0;
    apply_reset();
    check("rst_empty_const", 32'(empty_o), 32'd1);

    // Basic issue / commit / result.
    iss(4'd3, 1'b1);
    check("basic_head_id", 32'(head_id_o), 32'd3);
    check("basic_head_wb", 32'(head_wb_o), 32'd1);
    cmt(4'd3, 1'b0);
    res(4'd3);
    check("basic_empty", 32'(empty_o), 32'd1);
    check("basic_no_err", 32'(protocol_err_o), 32'd0);

    // Fill, then overflow.
    for (int i = 1; i <= 4; i++) iss(IDW'(i), 1'b0);
    check("fill_stall", 32'(issue_stall_o), 32'd1);
    iss(4'd5, 1'b0);
    check("overflow_err", 32'(protocol_err_o), 32'd1);
    check("overflow_count", 32'(count_o), 32'd4);

    // Kill chain.
    apply_reset();
    iss(4'd5, 1'b1); iss(4'd6, 1'b0); iss(4'd7, 1'b1);
    cmt(4'd5, 1'b1); cmt(4'd6, 1'b1); cmt(4'd7, 1'b0);
    check("kill_head", 32'(head_id_o), 32'd7);
    check("kill_count", 32'(count_o), 32'd1);
    res(4'd7);
    check("kill_empty", 32'(empty_o), 32'd1);

    // Same-cycle push and pop, continuing past a pointer wrap.
    iss(4'd10, 1'b0); iss(4'd11, 1'b1);
    cmt(4'd10, 1'b0);
    cyc(1, 1, 4'd9, 1'b1, 0, '0, 0, 1, 4'd10, "pp");
    check("pp_count", 32'(count_o), 32'd2);
    check("pp_head", 32'(head_id_o), 32'd11);
    cmt(4'd11, 1'b0); cyc(1, 1, 4'd12, 1'b0, 0, '0, 0, 1, 4'd11, "pp");
    cmt(4'd9, 1'b0);  cyc(1, 1, 4'd13, 1'b1, 0, '0, 0, 1, 4'd9, "pp");
    cmt(4'd12, 1'b0); cyc(1, 1, 4'd14, 1'b0, 0, '0, 0, 1, 4'd12, "pp");
    check("wrap_head", 32'(head_id_o), 32'd13);
    check("wrap_count", 32'(count_o), 32'd2);
    check("wrap_no_err", 32'(protocol_err_o), 32'd0);

    // Error cases, each from a clean state.
    apply_reset();
    iss(4'd1, 1'b0); cmt(4'd1, 1'b0); res(4'd2);
    check("err_res_id", 32'(protocol_err_o), 32'd1);
    check("err_res_id_count", 32'(count_o), 32'd1);
    apply_reset();
    iss(4'd1, 1'b0); res(4'd1);
    check("err_res_uncmt", 32'(protocol_err_o), 32'd1);
    check("err_res_uncmt_count", 32'(count_o), 32'd1);
    apply_reset();
    iss(4'd1, 1'b0); iss(4'd2, 1'b0); cmt(4'd2, 1'b0);
    check("err_cmt_order", 32'(protocol_err_o), 32'd1);
    check("err_cmt_order_head", 32'(head_id_o), 32'd1);
    apply_reset();
    cyc(1, 0, 4'd6, 1'b1, 0, '0, 0, 0, '0, "noacc");
    check("noacc_count", 32'(count_o), 32'd0);
    check("noacc_err", 32'(protocol_err_o), 32'd0);

    // Async reset mid-operation, no clock edge in between.
    apply_reset();
    iss(4'd1, 1'b1); iss(4'd2, 1'b0); iss(4'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_err = 1'b0;
    check_outputs("arst");
    check("arst_count", 32'(count_o), 32'd0);
    apply_reset();

    // Randomized traffic; odd blocks mix in protocol violations.
    for (int blk = 0; blk < 6; blk++) begin
      errmode = (blk % 2) == 1;
      apply_reset();
      repeat (200) begin
        idle_inputs();
        issue_valid     = ($urandom % 2) == 0;
        issue_ready     = ($urandom % 4) != 0;
        issue_accept    = ($urandom % 4) != 0;
        issue_id        = IDW'($urandom);
        issue_writeback = $urandom % 2;
        if (!errmode && mq.size() == DEPTH) issue_valid = 1'b0;
        ci = first_uncommitted();
        if (ci >= 0 && ($urandom % 2) == 0) begin
          commit_valid = 1'b1;
          commit_id    = mq[ci].id;
          commit_kill  = ($urandom % 3) == 0;
        end
        if (errmode && ($urandom % 10) == 0) begin
          commit_valid = 1'b1;
          commit_id    = IDW'($urandom);
        end
        if (mq.size() > 0 && mq[0].cmt && !mq[0].kil && ($urandom % 2) == 0) begin
          result_valid = 1'b1;
          result_ready = 1'b1;
          result_id    = mq[0].id;
        end else begin
          result_valid = ($urandom % 2) == 0;
          result_ready = 1'b0;
          result_id    = IDW'($urandom);
        end
        if (errmode && ($urandom % 10) == 0) begin
          result_valid = 1'b1;
          result_ready = 1'b1;
          result_id    = IDW'($urandom);
        end
        step("rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv32e40x_xif_outstanding_tracker.md
# cv32e40x_xif_outstanding_tracker

Core-side bookkeeping stage directly downstream of the eXtension interface issue and commit handshakes, upstream of the result writeback path. It records every offloaded instruction accepted by the coprocessor, tracks its commit or kill status in issue order, and retires it on the matching result handshake. It provides an issue stall when full, plus a sticky protocol error for XIF ordering violations.

## Interface
- DEPTH, 4: number of tracked outstanding instructions; power of two, ≥2.
- X_ID_WIDTH, 4: width of the offload ID.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  XIF issue_valid.
- issue_ready  in  1  XIF issue_ready.
- issue_id  in  X_ID_WIDTH  issue_req.id.
- issue_accept  in  1  issue_resp.accept.
- issue_writeback  in  1  issue_resp.writeback.
- commit_valid  in  1  XIF commit_valid.
- commit_id  in  X_ID_WIDTH  commit.id.
- commit_kill  in  1  commit.commit_kill.
- result_valid  in  1  XIF result_valid.
- result_ready  in  1  XIF result_ready.
- result_id  in  X_ID_WIDTH  result.id.
- issue_stall_o  out  1  tracker full; issuer must hold issue_valid low.
- empty_o  out  1  no outstanding entries.
- count_o  out  $clog2(DEPTH)+1  number of outstanding entries.
- head_id_o  out  X_ID_WIDTH  ID of oldest entry (0 when empty).
- head_wb_o  out  1  oldest entry expects register writeback.
- protocol_err_o  out  1  sticky ordering/overflow error.

## Operation
- Entry fields: id, writeback, committed, killed. Circular buffer with wr_ptr, cmt_ptr, rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- Push: issue_valid & issue_ready & issue_accept & !full. Write {issue_id, issue_writeback, 0, 0} at wr_ptr. Non-accepted issues are ignored.
- Push while full: entry dropped, protocol_err set.
- Commit: commit_valid marks the entry at cmt_ptr (committed=1, killed=commit_kill) and advances cmt_ptr. Commits are strictly in issue order.
- A commit is an error, and changes no state, if cmt_ptr==wr_ptr with no uncommitted stored entry, or if commit_id != stored id. A commit may target only entries stored in an earlier cycle.
- Retire-by-kill: head committed & killed pops the head with no result expected.
- Retire-by-result: result_valid & result_ready pops the head. The handshake is an error, with no pop, if the tracker is empty, result_id != head id, the head is uncommitted, or the head is killed.
- Pops per cycle: at most one. A result handshake cannot coincide with a killed head, because that case is an error.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into the slot freed by the same-cycle pop is allowed only when count<DEPTH before the cycle; full is judged on registered count.
- protocol_err clears only on reset.

## Timing
- Reset (async assert, sync release by the system): all pointers 0, count 0, all entries 0. Outputs: issue_stall_o=0, empty_o=1, count_o=0, head_id_o=0, head_wb_o=0, protocol_err_o=0.
- Reset mid-operation discards all outstanding entries immediately.
- All outputs are registered-state driven, with no combinational path from inputs.
- Push and commit are visible on outputs the cycle after the handshake.
- A killed head pops one cycle after its commit is recorded, so an entry killed at cycle N is gone at N+2. A chain of killed entries retires one per cycle.
- issue_stall_o=1 exactly when count==DEPTH.
- protocol_err_o rises the cycle after the offending handshake.

## Structure
- Entry struct (xif_trk_entry_t) goes in cv32e40x_pkg, parameterised via X_ID_WIDTH-sized field handled by the tracker, or declared inside the module if the package cannot carry the parameter.
- No sub-module. Pointer and count logic is inline; estimated 150–250 lines.

## Test plan
- Reset: count_o=0, empty_o=1, protocol_err_o=0. Issue id 3 accept wb=1 → count_o=1, head_id_o=3, head_wb_o=1. Commit id 3, kill=0, then result id 3 → empty_o=1, no error.
- Fill (DEPTH=4): issue ids 1,2,3,4 all accepted → issue_stall_o=1. A 5th handshake sets protocol_err_o and leaves count_o=4.
- Kill chain: issue 5,6,7, then commit 5 kill=1, 6 kill=1, 7 kill=0 on consecutive cycles. Heads 5 and 6 retire unaided, head_id_o=7, count_o=1. Result 7 → empty.
- Same-cycle push/pop: count=2, result handshake on head while issuing id 9 → count_o stays 2, head advances, id 9 at tail. Pointers wrap after 8 total pushes with correct head_id_o.
- Errors: result id mismatch; result on uncommitted head; commit id 2 when id 1 is expected; issue_accept=0 ignored with count unchanged. Each error sets protocol_err_o with no state change.
- Async reset asserted with 3 entries outstanding → all outputs return to reset values without a clock edge.
